// File: rtl/hazard_unit.sv
// Pipeline control for the RV32I 5-stage core: stalls, flushes, operand
// forwarding selects and stall/flush performance counters.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic       mem_wait;
  logic       load_use;
  logic [9:0] ex_src;
  logic [9:0] id_src;
  logic [1:0] id_uses;
  logic [1:0] id_hit;
  logic [3:0] fwd_sel;

  assign ex_src  = {ex_rs2, ex_rs1};
  assign id_src  = {id_rs2, id_rs1};
  assign id_uses = {id_uses_rs2, id_uses_rs1};

  // Per-operand forwarding select (MEM beats WB) and load-use match.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign fwd_sel[2*gi +: 2] =
        !rst ? 2'b00 :
        (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_src[5*gi +: 5])) ? 2'b01 :
        (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_src[5*gi +: 5])) ? 2'b10 :
        2'b00;
      assign id_hit[gi] = id_uses[gi] && (id_src[5*gi +: 5] == ex_rd);
    end
  endgenerate

  assign fwd_a = fwd_sel[1:0];
  assign fwd_b = fwd_sel[3:2];

  assign mem_wait = mem_req && !mem_ready;
  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) && (|id_hit);

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    state_next = RUN;
    if (rst) begin
      if (mem_wait) begin
        state_next = MEM_WAIT;
      end else if (ex_branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        state_next = FLUSH;
      end else if (load_use && (state_reg != LOAD_STALL) && (state_reg != FLUSH)) begin
        // EX already holds a bubble after a stall or flush, so a match then is stale.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        state_next = LOAD_STALL;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!pc_en)
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      if (ifid_flush)
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
    end
  end

  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised and directed bench for hazard_unit, checked against a cycle-level
// behavioural model; a second 4-bit-counter instance covers counter wrap.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic       mem_reg_write, mem_req, mem_ready, wb_reg_write;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4;
  logic [1:0]  fwd_a4, fwd_b4, state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_en(idex_en4),
    .idex_flush(idex_flush4), .exmem_en(exmem_en4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // Control outputs packed as {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}.
  logic [5:0] a_ctrl;
  assign a_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: architectural state, counters and expected controls.
  logic [1:0]  m_state;
  logic [31:0] m_stall, m_flush;
  logic [5:0]  e_ctrl;
  logic [1:0]  e_fa, e_fb, e_next;

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function void predict();
    bit mw, lu;
    mw = mem_req && !mem_ready;
    lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e_fa = 2'b00; e_fb = 2'b00; e_ctrl = 6'b000000; e_next = 2'd0;
    if (rst) begin
      e_fa = fwd_of(ex_rs1);
      e_fb = fwd_of(ex_rs2);
      if (mw) begin
        e_next = 2'd3;
      end else if (ex_branch_taken) begin
        e_ctrl = 6'b111111; e_next = 2'd2;
      end else if (lu && m_state != 2'd1 && m_state != 2'd2) begin
        e_ctrl = 6'b000111; e_next = 2'd1;
      end else begin
        e_ctrl = 6'b110101;
      end
    end
  endfunction

  task automatic tick();
    $display("t=%0t rst=%b st=%0d ctrl=%b fa=%b fb=%b stall=%0d flush=%0d",
             $time, rst, state, a_ctrl, fwd_a, fwd_b, stall_cnt, flush_cnt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = e_next;
      if (!e_ctrl[5]) m_stall++;
      if (e_ctrl[3])  m_flush++;
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_stall = 0; m_flush = 0;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read, ex_branch_taken} = '0;
    {mem_reg_write, mem_req, mem_ready, wb_reg_write} = '0;
  endtask

  task automatic rand_inputs();
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
    wb_rd  = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
    ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
    mem_req = ($urandom_range(0, 3) == 0); mem_ready = 1'($urandom);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, fwd_a, fwd_b} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_outputs ctrl=%b fa=%b fb=%b required all zero", a_ctrl, fwd_a, fwd_b);
      end
      n_chk++;
      if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || stall_cnt4 !== 0) begin
        n_fail++;
        $display("FAIL reset_state st=%0d stall=%0d flush=%0d required 0/0/0", state, stall_cnt, flush_cnt);
      end
      tick();
    end
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    clear_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 9;
    s0 = m_stall;
    for (int c = 0; c < 2; c++) begin
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, fwd_a, fwd_b, state} !== {e_ctrl, e_fa, e_fb, m_state}) begin
        n_fail++;
        $display("FAIL load_use_model cyc=%0d ctrl=%b st=%0d required ctrl=%b st=%0d", c, a_ctrl, state, e_ctrl, m_state);
      end
      n_chk++;
      if (c == 0 && {pc_en, ifid_en, idex_en, idex_flush} !== 4'b0011) begin
        n_fail++;
        $display("FAIL load_use_stall pc/ifid/idex/idexf=%b required 0011", {pc_en, ifid_en, idex_en, idex_flush});
      end else if (c == 1 && (state !== 2'd1 || a_ctrl !== 6'b110101 || stall_cnt !== s0 + 1)) begin
        n_fail++;
        $display("FAIL load_use_after st=%0d ctrl=%b stall=%0d required 1 110101 %0d", state, a_ctrl, stall_cnt, s0 + 1);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    // {mem_rd, wb_rd, ex_rs1, ex_rs2, mem_reg_write, wb_reg_write, fa, fb}
    logic [25:0] tbl [4];
    tbl[0] = {5'd7, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'b01, 2'b00};
    tbl[1] = {5'd0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[2] = {5'd3, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[3] = {5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 1'b1, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      {mem_rd, wb_rd, ex_rs1, ex_rs2, mem_reg_write, wb_reg_write} = tbl[i][25:4];
      #2;
      predict();
      n_chk++;
      if ({fwd_a, fwd_b} !== tbl[i][3:0] || {fwd_a, fwd_b} !== {e_fa, e_fb}) begin
        n_fail++;
        $display("FAIL forwarding case=%0d fa=%b fb=%b required %b", i, fwd_a, fwd_b, tbl[i][3:0]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_branch_flush();
    logic [31:0] f0;
    clear_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 6; id_rs2 = 6; id_uses_rs2 = 1;
    ex_branch_taken = 1;
    f0 = m_flush;
    for (int c = 0; c < 3; c++) begin
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, state, flush_cnt, flush_cnt4} !== {e_ctrl, m_state, m_flush, m_flush[3:0]}) begin
        n_fail++;
        $display("FAIL branch_model cyc=%0d ctrl=%b st=%0d flush=%0d required %b %0d %0d", c, a_ctrl, state, flush_cnt, e_ctrl, m_state, m_flush);
      end
      n_chk++;
      if (c == 0 && {pc_en, ifid_flush, idex_flush} !== 3'b111) begin
        n_fail++;
        $display("FAIL branch_flush pc/ifidf/idexf=%b required 111", {pc_en, ifid_flush, idex_flush});
      end else if (c == 1 && (state !== 2'd2 || a_ctrl !== 6'b110101 || flush_cnt !== f0 + 1)) begin
        n_fail++;
        $display("FAIL branch_after st=%0d ctrl=%b flush=%0d required 2 110101 %0d", state, a_ctrl, flush_cnt, f0 + 1);
      end
      tick();
      ex_branch_taken = 0;
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    clear_inputs();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    s0 = m_stall;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1;
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, state} !== {e_ctrl, m_state}) begin
        n_fail++;
        $display("FAIL mem_wait_model cyc=%0d ctrl=%b st=%0d required %b %0d", c, a_ctrl, state, e_ctrl, m_state);
      end
      n_chk++;
      if (c < 3 && a_ctrl !== 6'b000000) begin
        n_fail++;
        $display("FAIL mem_wait_freeze cyc=%0d ctrl=%b required 000000", c, a_ctrl);
      end else if (c == 3 && (a_ctrl !== 6'b111111 || state !== 2'd3 || stall_cnt !== s0 + 3)) begin
        n_fail++;
        $display("FAIL mem_wait_release ctrl=%b st=%0d stall=%0d required 111111 3 %0d", a_ctrl, state, stall_cnt, s0 + 3);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    mem_rd = 8; ex_rs1 = 8; mem_reg_write = 1;
    for (int c = 0; c < 2; c++) begin
      #2;
      predict();
      tick();
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0 || stall_cnt4 !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_wait st=%0d stall=%0d flush=%0d required 0/0/0", state, stall_cnt, flush_cnt);
    end
    n_chk++;
    if ({a_ctrl, fwd_a, fwd_b} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait_outputs ctrl=%b fa=%b required zero", a_ctrl, fwd_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    ex_rs1 = 3; wb_rd = 3; wb_reg_write = 1;
    for (int c = 0; c < 2; c++) begin
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, fwd_a, state, stall_cnt, flush_cnt} !== {6'b110101, 2'b10, 2'd0, 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL after_reset_run ctrl=%b fa=%b st=%0d stall=%0d required 110101 10 0 0", a_ctrl, fwd_a, state, stall_cnt);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_counter_wrap();
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 0; c < 17; c++) begin
      #1;
      predict();
      tick();
    end
    clear_inputs();
    #2;
    n_chk++;
    if (stall_cnt4 !== 4'd1 || stall_cnt !== 32'd17) begin
      n_fail++;
      $display("FAIL counter_wrap stall4=%0d stall32=%0d required 1 17", stall_cnt4, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      #2;
      predict();
      n_chk++;
      if ({a_ctrl, fwd_a, fwd_b, state} !== {e_ctrl, e_fa, e_fb, m_state}) begin
        n_fail++;
        $display("FAIL random_ctrl cyc=%0d ctrl=%b fa=%b fb=%b st=%0d required %b %b %b %0d",
                 c, a_ctrl, fwd_a, fwd_b, state, e_ctrl, e_fa, e_fb, m_state);
      end
      n_chk++;
      if ({stall_cnt, flush_cnt, stall_cnt4, flush_cnt4} !== {m_stall, m_flush, m_stall[3:0], m_flush[3:0]}) begin
        n_fail++;
        $display("FAIL random_cnt cyc=%0d stall=%0d flush=%0d s4=%0d f4=%0d required %0d %0d",
                 c, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, m_stall, m_flush);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_mem_wait();
    test_reset_mid_wait();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
